// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage rv32i pipeline: load-use bubbles, memory waits, branch flushes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.

package regfilemux;
   typedef enum logic [3:0] {
      alu_out, br_en, u_imm, lw, pc_plus4, lb, lbu, lh, lhu
   } regfilemux_sel_t;
endpackage

// state    | meaning
// RUN      | normal flow; detects mem stalls, branch redirects, load-use hazards
// LU_STALL | single bubble cycle after a load-use hazard
// MEM_WAIT | frozen pipeline awaiting imem/dmem response; may hold a pending flush
module hazard_stall_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [4:0]                   IF_ID_rs1,
   input  logic [4:0]                   IF_ID_rs2,
   input  logic                         IF_ID_uses_rs1,
   input  logic                         IF_ID_uses_rs2,
   input  logic [4:0]                   ID_EX_rd,
   input  regfilemux::regfilemux_sel_t  ID_EX_regfile_sel,
   input  logic                         ID_EX_load_regfile,
   input  logic                         br_taken,
   input  logic                         imem_read,
   input  logic                         imem_resp,
   input  logic                         dmem_req,
   input  logic                         dmem_resp,
   output logic                         load_pc,
   output logic                         load_IF_ID,
   output logic                         load_ID_EX,
   output logic                         load_EX_MEM,
   output logic                         load_MEM_WB,
   output logic                         flush_IF_ID,
   output logic                         flush_ID_EX,
   output logic [CNT_W-1:0]             perf_stall_cnt,
   output logic [CNT_W-1:0]             perf_lu_cnt,
   output logic [CNT_W-1:0]             perf_flush_cnt
);

   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

   state_t state;
   logic   flush_pend;
   logic   mem_stall;
   logic   is_load;
   logic   lu_haz;
   logic   lu_enter;

   assign mem_stall = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);

   always_comb begin
      is_load = ID_EX_regfile_sel inside {regfilemux::lb, regfilemux::lbu, regfilemux::lh,
                                          regfilemux::lhu, regfilemux::lw};
   end

   assign lu_haz = ID_EX_load_regfile & is_load & (ID_EX_rd != 5'd0) &
                   ((IF_ID_uses_rs1 & (IF_ID_rs1 == ID_EX_rd)) |
                    (IF_ID_uses_rs2 & (IF_ID_rs2 == ID_EX_rd)));

   assign lu_enter = (state == RUN) & ~mem_stall & ~br_taken & lu_haz;

   always_comb begin
      load_pc     = 1'b0;
      load_IF_ID  = 1'b0;
      load_ID_EX  = 1'b0;
      load_EX_MEM = 1'b0;
      load_MEM_WB = 1'b0;
      flush_IF_ID = 1'b0;
      flush_ID_EX = 1'b0;
      if (!rst) begin
         flush_IF_ID = 1'b1;
         flush_ID_EX = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (!mem_stall) begin
                  load_ID_EX  = 1'b1;
                  load_EX_MEM = 1'b1;
                  load_MEM_WB = 1'b1;
                  if (br_taken) begin
                     load_pc     = 1'b1;
                     load_IF_ID  = 1'b1;
                     flush_IF_ID = 1'b1;
                     flush_ID_EX = 1'b1;
                  end else if (lu_haz) begin
                     flush_ID_EX = 1'b1;
                  end else begin
                     load_pc    = 1'b1;
                     load_IF_ID = 1'b1;
                  end
               end
            end
            LU_STALL, MEM_WAIT: begin
               if (!mem_stall) begin
                  load_pc     = 1'b1;
                  load_IF_ID  = 1'b1;
                  load_ID_EX  = 1'b1;
                  load_EX_MEM = 1'b1;
                  load_MEM_WB = 1'b1;
                  if (state == MEM_WAIT) begin
                     flush_IF_ID = flush_pend;
                     flush_ID_EX = flush_pend;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_stall) begin
                  state <= MEM_WAIT;
                  if (br_taken) flush_pend <= 1'b1;
               end else if (lu_enter) begin
                  state <= LU_STALL;
               end
            end
            LU_STALL: state <= mem_stall ? MEM_WAIT : RUN;
            MEM_WAIT: begin
               if (mem_stall) begin
                  if (br_taken) flush_pend <= 1'b1;
               end else begin
                  flush_pend <= 1'b0;
                  state      <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, lu_q, flush_q;

   // Counters saturate rather than wrap so long runs never read as short ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         lu_q    <= '0;
         flush_q <= '0;
      end else begin
         if (!load_pc && stall_q != '1)    stall_q <= stall_q + CNT_W'(1);
         if (lu_enter && lu_q != '1)       lu_q    <= lu_q + CNT_W'(1);
         if (flush_IF_ID && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign perf_stall_cnt = stall_q;
   assign perf_lu_cnt    = lu_q;
   assign perf_flush_cnt = flush_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_lu_cnt    = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule
